lsu_pipe: RTL and testbench
===========================

Name: lsu_pipe

Overview:
- Load/store execution pipe of the VLIW core; one instance per LSU slot.
- Takes an issued LSU op and reads its operands through its dedicated register-file read ports (lsu_rs1/lsu_rs2 → lsu_rd_data1/lsu_rd_data2).
- Computes the address, runs a valid/ready memory transaction and drives the register-file LSU write port (lsu_wr_addr/lsu_wr_data/lsu_wr_en) for loads.
- Sits directly upstream and downstream of the register file for the LSU slot.

Parameters:
- XLEN, 32, data and address width.
- IMM_W, 12, width of the signed address offset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  LSU op presented.
- issue_ready  out  1  pipe idle and able to accept.
- issue_is_store  in  1  1 = store, 0 = load.
- issue_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- issue_unsigned  in  1  zero-extend loads.
- issue_rd  in  5  load destination register.
- issue_rs1  in  5  base register.
- issue_rs2  in  5  store data register.
- issue_imm  in  IMM_W  signed offset.
- lsu_rs1, lsu_rs2  out  5 each  register-file read addresses (combinational from issue_rs1/issue_rs2).
- lsu_rd_data1, lsu_rd_data2  in  XLEN each  register-file read data (combinational).
- lsu_wr_addr  out  5  write-back address.
- lsu_wr_data  out  XLEN  write-back data.
- lsu_wr_en  out  1  write-back strobe.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  store request.
- mem_req_addr  out  XLEN  word-aligned address (bits 1:0 = 0).
- mem_req_wdata  out  XLEN  lane-shifted store data.
- mem_req_be  out  4  byte enables.
- mem_rsp_valid  in  1  load data returned.
- mem_rsp_rdata  in  XLEN  full load word.
- err_misaligned  out  1  one-cycle pulse on a misaligned or illegal-size op.

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0 except issue_ready = 1.
  - Any in-flight request or expected response is dropped.
  - A mem_rsp_valid arriving after reset is ignored.
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - issue_ready = 1. Accept when issue_valid is high.
  - On accept, capture:
    - ea = lsu_rd_data1 + sign_extend(issue_imm), mod 2^XLEN.
    - rs2 data, rd, size, unsigned, is_store.
  - Misalignment check: half with ea[0] = 1, word with ea[1:0] ≠ 0, or size = 3.
    - On misalignment: pulse err_misaligned on the next cycle, stay in IDLE, no memory request, no write.
    - Otherwise: go to REQ.
- REQ:
  - mem_req_valid = 1. addr, we, wdata and be are held stable until mem_req_ready is high.
  - Store on handshake → IDLE. Load on handshake → WAIT.
  - mem_req_valid must not drop before the handshake.
- WAIT:
  - On mem_rsp_valid, register the aligned and extended data → WB.
  - A response in the same cycle as the request handshake is not allowed; the memory responds at least 1 cycle later.
- WB:
  - lsu_wr_en = 1 for exactly one cycle, with lsu_wr_addr = rd. Then → IDLE.
  - If rd = 0, lsu_wr_en stays 0; the pipe still passes through WB.
- Byte lanes:
  - be: byte = 1 << ea[1:0]; half = 3 << ea[1:0]; word = 4'hF.
  - wdata = store data replicated into the addressed lane(s).
  - Load: select lane by ea[1:0], then sign- or zero-extend.
- Latency:
  - Store with ready already high: accept at cycle 0, handshake at cycle 1, issue_ready at cycle 2.
  - Load with 1-cycle memory: handshake at cycle 1, rsp at cycle 2, wr_en at cycle 3, issue_ready at cycle 4.
- Throughput: 1 op outstanding; issue_ready = 0 in every state other than IDLE.

Decomposition:
- vliw_pkg holds:
  - lsu_size_t (SZ_B, SZ_H, SZ_W).
  - lsu_state_t (IDLE, REQ, WAIT, WB).
  - XLEN constant.
- Sub-module lsu_align is combinational and does lane selection, extension, byte-enable and wdata generation. It is instantiated once.

Test Plan:
- Word store: rs1 holds 0x1000, imm = 8, rs2 holds 0xDEADBEEF, ready held 0 for 3 cycles → valid stays high and stable with addr 0x1008, be 4'hF, wdata 0xDEADBEEF; issue_ready returns 1 the cycle after the handshake.
- Signed byte load: ea = 0x2003, rsp rdata 0x80112233 → lsu_wr_data 0xFFFFFF80 to rd = 5 for one cycle. Unsigned variant → 0x00000080.
- Half store: ea = 0x2002, rs2 holds 0x0000ABCD → be 4'b1100, wdata 0xABCDABCD. Half load at 0x2001 → err_misaligned pulse, no mem_req_valid, no write.
- Load to rd = 0 → full handshake occurs, lsu_wr_en never asserts.
- Negative imm: rs1 holds 0x10, imm = -16 → addr 0x0. rs1 holds 0x4, imm = -8 → addr 0xFFFFFFFC (wrap).
- Reset asserted in WAIT, then a late mem_rsp_valid → state IDLE, no write, issue_ready = 1.

Source files
------------

// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared types and widths for the VLIW load/store pipe
package vliw_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: enables, store replication, load extract/extend, alignment check
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      ea_lo,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic            misaligned
);
  import vliw_pkg::*;

  logic [XLEN-1:0] lane;

  always_comb begin
    // Bring the addressed byte/half down to bit 0 before extending.
    lane       = rdata >> {ea_lo, 3'b000};
    be         = 4'h0;
    wdata      = st_data;
    ld_data    = lane;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be      = 4'b0001 << ea_lo;
        wdata   = {(XLEN/8){st_data[7:0]}};
        ld_data = {{(XLEN-8){~is_unsigned & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        be         = 4'b0011 << ea_lo;
        wdata      = {(XLEN/16){st_data[15:0]}};
        ld_data    = {{(XLEN-16){~is_unsigned & lane[15]}}, lane[15:0]};
        misaligned = ea_lo[0];
      end
      SZ_W: begin
        be         = 4'hF;
        misaligned = |ea_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - single-outstanding load/store pipe between register file and memory port
module lsu_pipe #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_is_store,
  input  logic [1:0]       issue_size,
  input  logic             issue_unsigned,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [IMM_W-1:0] issue_imm,
  output logic [4:0]       lsu_rs1,
  output logic [4:0]       lsu_rs2,
  input  logic [XLEN-1:0]  lsu_rd_data1,
  input  logic [XLEN-1:0]  lsu_rd_data2,
  output logic [4:0]       lsu_wr_addr,
  output logic [XLEN-1:0]  lsu_wr_data,
  output logic             lsu_wr_en,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [XLEN-1:0]  mem_req_wdata,
  output logic [3:0]       mem_req_be,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_rdata,
  output logic             err_misaligned
);
  import vliw_pkg::*;

  lsu_state_t      state;
  logic [1:0]      size_q;
  logic [1:0]      ea_lo_q;
  logic            uns_q;
  logic [4:0]      rd_q;
  logic            idle;
  logic [XLEN-1:0] ea;
  logic [1:0]      a_size;
  logic [1:0]      a_lo;
  logic            a_uns;
  logic [3:0]      a_be;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_ld;
  logic            a_mis;

  assign lsu_rs1 = issue_rs1;
  assign lsu_rs2 = issue_rs2;
  assign idle    = (state == IDLE);
  assign ea      = lsu_rd_data1 + {{(XLEN-IMM_W){issue_imm[IMM_W-1]}}, issue_imm};

  // One aligner serves both phases: issue-time fields while idle, captured fields afterwards.
  assign a_size = idle ? issue_size       : size_q;
  assign a_lo   = idle ? ea[1:0]          : ea_lo_q;
  assign a_uns  = idle ? issue_unsigned   : uns_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size        (a_size),
    .is_unsigned (a_uns),
    .ea_lo       (a_lo),
    .st_data     (lsu_rd_data2),
    .rdata       (mem_rsp_rdata),
    .be          (a_be),
    .wdata       (a_wdata),
    .ld_data     (a_ld),
    .misaligned  (a_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      issue_ready    <= 1'b1;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_be     <= 4'h0;
      lsu_wr_en      <= 1'b0;
      lsu_wr_addr    <= 5'd0;
      lsu_wr_data    <= '0;
      err_misaligned <= 1'b0;
      size_q         <= 2'd0;
      ea_lo_q        <= 2'd0;
      uns_q          <= 1'b0;
      rd_q           <= 5'd0;
    end else begin
      err_misaligned <= 1'b0;
      lsu_wr_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid) begin
            if (a_mis) begin
              err_misaligned <= 1'b1;
            end else begin
              state         <= REQ;
              issue_ready   <= 1'b0;
              mem_req_valid <= 1'b1;
              mem_req_we    <= issue_is_store;
              mem_req_addr  <= {ea[XLEN-1:2], 2'b00};
              mem_req_wdata <= issue_is_store ? a_wdata : '0;
              mem_req_be    <= a_be;
              size_q        <= issue_size;
              ea_lo_q       <= ea[1:0];
              uns_q         <= issue_unsigned;
              rd_q          <= issue_rd;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_req_we) begin
              state       <= IDLE;
              issue_ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state       <= WB;
            lsu_wr_addr <= rd_q;
            lsu_wr_data <= a_ld;
            lsu_wr_en   <= (rd_q != 5'd0);
          end
        end
        default: begin
          state       <= IDLE;
          issue_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// tb/tb_lsu_pipe.sv - scoreboard bench for lsu_pipe with a register-file and memory model
module tb_lsu_pipe;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        lanes;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_is_store, issue_unsigned;
  logic [1:0]  issue_size;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic [11:0] issue_imm;
  logic [4:0]  lsu_rs1, lsu_rs2, lsu_wr_addr;
  logic [31:0] lsu_rd_data1, lsu_rd_data2, lsu_wr_data;
  logic        lsu_wr_en;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        err_misaligned;

  logic [31:0] regs [32];
  req_t        req_q [$];
  wr_t         wr_q [$];
  int          err_exp = 0;
  int          checks = 0;
  int          errors = 0;

  int          stall_cycles = 0;
  int          stall_cnt = 0;
  logic [31:0] rsp_word = '0;
  logic        no_rsp = 1'b0;
  logic        force_rsp = 1'b0;
  logic        hs_load = 1'b0;

  always #5 clk = ~clk;

  assign lsu_rd_data1 = regs[lsu_rs1];
  assign lsu_rd_data2 = regs[lsu_rs2];

  lsu_pipe #(.XLEN(32), .IMM_W(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_is_store (issue_is_store),
    .issue_size     (issue_size),
    .issue_unsigned (issue_unsigned),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_imm      (issue_imm),
    .lsu_rs1        (lsu_rs1),
    .lsu_rs2        (lsu_rs2),
    .lsu_rd_data1   (lsu_rd_data1),
    .lsu_rd_data2   (lsu_rd_data2),
    .lsu_wr_addr    (lsu_wr_addr),
    .lsu_wr_data    (lsu_wr_data),
    .lsu_wr_en      (lsu_wr_en),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata),
    .err_misaligned (err_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic we, input logic [31:0] addr, input logic lanes,
                         input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.we = we; r.addr = addr; r.lanes = lanes; r.be = be; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    int n = 0;
    while (!issue_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("issue_ready_timeout", 32'(issue_ready), 32'd1);
    issue_valid = 1'b1; issue_is_store = st; issue_size = sz; issue_unsigned = uns;
    issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!issue_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(issue_ready), 32'd1);
  endtask

  // Memory model: optional stall on ready, load response one cycle after the handshake.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = (hs_load && !no_rsp) || force_rsp;
      mem_rsp_rdata = mem_rsp_valid ? rsp_word : 32'h0;
      if (mem_req_valid && stall_cnt < stall_cycles) begin
        mem_req_ready = 1'b0;
        stall_cnt++;
      end else begin
        mem_req_ready = mem_req_valid;
      end
      hs_load = mem_req_valid && mem_req_ready && !mem_req_we && !rst;
      if (mem_req_valid && mem_req_ready) stall_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %h we %b, none expected", mem_req_addr, mem_req_we);
        end else begin
          chk("req_we", 32'(mem_req_we), 32'(req_q[0].we));
          chk("req_addr", mem_req_addr, req_q[0].addr);
          if (req_q[0].lanes) begin
            chk("req_be", 32'(mem_req_be), 32'(req_q[0].be));
            chk("req_wdata", mem_req_wdata, req_q[0].wdata);
          end
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (lsu_wr_en) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: rd %0d data %h, none expected", lsu_wr_addr, lsu_wr_data);
        end else begin
          chk("wr_addr", 32'(lsu_wr_addr), 32'(wr_q[0].addr));
          chk("wr_data", lsu_wr_data, wr_q[0].data);
          void'(wr_q.pop_front());
        end
      end
      if (err_misaligned) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL unexpected_err: err_misaligned 1, expected 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst = 1'b1;
    issue_valid = 1'b0; issue_is_store = 1'b0; issue_size = 2'd0; issue_unsigned = 1'b0;
    issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_imm = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wr_en", 32'(lsu_wr_en), 32'd0);
    chk("rst_err", 32'(err_misaligned), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    regs[1] = 32'h1000; regs[2] = 32'hDEADBEEF; regs[3] = 32'h2000; regs[4] = 32'h0000ABCD;
    regs[6] = 32'h10;   regs[7] = 32'h4;        regs[8] = 32'h000000A5;

    stall_cycles = 3;
    exp_req(1'b1, 32'h1008, 1'b1, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 1'b0, 5'd0, 5'd1, 5'd2, 12'd8);
    wait_idle(n);
    chk("store_latency", 32'(n), 32'd4);
    stall_cycles = 0;

    rsp_word = 32'h80112233;
    exp_req(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0);
    exp_wr(5'd5, 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b0, 5'd5, 5'd3, 5'd0, 12'd3);
    wait_idle(n);
    chk("load_latency", 32'(n), 32'd3);

    exp_req(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0);
    exp_wr(5'd5, 32'h00000080);
    issue(1'b0, 2'd0, 1'b1, 5'd5, 5'd3, 5'd0, 12'd3);
    wait_idle(n);

    exp_req(1'b1, 32'h2000, 1'b1, 4'b1100, 32'hABCDABCD);
    issue(1'b1, 2'd1, 1'b0, 5'd0, 5'd3, 5'd4, 12'd2);
    wait_idle(n);

    err_exp++;
    issue(1'b0, 2'd1, 1'b0, 5'd6, 5'd3, 5'd0, 12'd1);
    chk("misaligned_issue_ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;

    exp_req(1'b0, 32'h2004, 1'b0, 4'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 5'd0, 5'd3, 5'd0, 12'd4);
    wait_idle(n);

    exp_req(1'b1, 32'h0, 1'b1, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 1'b0, 5'd0, 5'd6, 5'd2, 12'hFF0);
    wait_idle(n);

    rsp_word = 32'h12345678;
    exp_req(1'b0, 32'hFFFFFFFC, 1'b0, 4'h0, 32'h0);
    exp_wr(5'd9, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 5'd9, 5'd7, 5'd0, 12'hFF8);
    wait_idle(n);

    rsp_word = 32'h80112233;
    exp_req(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0);
    exp_wr(5'd11, 32'hFFFF8011);
    issue(1'b0, 2'd1, 1'b0, 5'd11, 5'd3, 5'd0, 12'd2);
    wait_idle(n);

    exp_req(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0);
    exp_wr(5'd12, 32'h00000022);
    issue(1'b0, 2'd0, 1'b0, 5'd12, 5'd3, 5'd0, 12'd1);
    wait_idle(n);

    exp_req(1'b1, 32'h2000, 1'b1, 4'b0010, 32'hA5A5A5A5);
    issue(1'b1, 2'd0, 1'b0, 5'd0, 5'd3, 5'd8, 12'd1);
    wait_idle(n);

    err_exp++;
    issue(1'b0, 2'd3, 1'b0, 5'd13, 5'd3, 5'd0, 12'd0);
    err_exp++;
    issue(1'b0, 2'd2, 1'b0, 5'd13, 5'd3, 5'd0, 12'd2);
    @(posedge clk); #1;

    no_rsp = 1'b1;
    exp_req(1'b0, 32'h2000, 1'b0, 4'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 5'd10, 5'd3, 5'd0, 12'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    no_rsp = 1'b0;
    rsp_word = 32'hCAFEF00D;
    @(negedge clk); force_rsp = 1'b1;
    @(negedge clk); force_rsp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("post_rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("post_rst_wr_en", 32'(lsu_wr_en), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("err_pending", 32'(err_exp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
